// File: rtl/logicnets_pkg.sv
// Shared constants, types and helpers for the LogicNets LUT layer.
package logicnets_pkg;

  localparam int unsigned FanInDefault    = 6;
  localparam int unsigned NNeuronsDefault = 8;

  typedef logic [$clog2(NNeuronsDefault)-1:0] neuron_idx_t;

  // Number of truth-table entries for a neuron with the given fan-in.
  function automatic int unsigned tbl_depth(input int unsigned fan_in);
    return 2 ** fan_in;
  endfunction

endpackage

// File: rtl/logicnets_lut_neuron.sv
// One LogicNets neuron: a run-time writable truth table with a lookup port
// and a configuration read-back port.
module logicnets_lut_neuron
  import logicnets_pkg::*;
#(
  parameter int unsigned FAN_IN   = FanInDefault,
  parameter int unsigned OUT_BITS = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [FAN_IN-1:0]   cfg_addr_i,
  input  logic [OUT_BITS-1:0] wdata_i,
  input  logic [FAN_IN-1:0]   laddr_i,
  output logic [OUT_BITS-1:0] ldata_o,
  output logic [OUT_BITS-1:0] rdata_o
);

  localparam int unsigned Depth = tbl_depth(FAN_IN);

  logic [OUT_BITS-1:0] tbl_q [Depth];
  logic [OUT_BITS-1:0] tbl_d [Depth];

  // Table update: a single entry changes on a gated write strobe.
  always_comb begin
    tbl_d = tbl_q;
    if (we_i) tbl_d[cfg_addr_i] = wdata_i;
  end

  // Table storage; reads below see the pre-write value during a write cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tbl_q <= '{default: '0};
    else       tbl_q <= tbl_d;
  end

  assign ldata_o = tbl_q[laddr_i];
  assign rdata_o = tbl_q[cfg_addr_i];

endmodule

// File: rtl/logicnets_lut_layer.sv
// Two-stage pipelined layer of LUT neurons with valid/ready backpressure
// and a table configuration/read-back port.
module logicnets_lut_layer
  import logicnets_pkg::*;
#(
  parameter int unsigned N_NEURONS = NNeuronsDefault,
  parameter int unsigned FAN_IN    = FanInDefault,
  parameter int unsigned OUT_BITS  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_NEURONS*FAN_IN-1:0]     in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [N_NEURONS*OUT_BITS-1:0]   out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic                            cfg_we,
  input  logic                            cfg_re,
  input  logic [$clog2(N_NEURONS)-1:0]    cfg_neuron,
  input  logic [FAN_IN-1:0]               cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_wdata,
  output logic [OUT_BITS-1:0]             cfg_rdata,
  output logic                            cfg_rvalid
);

  localparam int unsigned NW = $clog2(N_NEURONS);

  logic                          s1_valid_q, s1_valid_d;
  logic [N_NEURONS*FAN_IN-1:0]   s1_data_q, s1_data_d;
  logic                          out_valid_q, out_valid_d;
  logic [N_NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
  logic [OUT_BITS-1:0]           cfg_rdata_q, cfg_rdata_d;
  logic                          cfg_rvalid_q, cfg_rvalid_d;

  logic [N_NEURONS*OUT_BITS-1:0] lut_out;
  logic [OUT_BITS-1:0]           rb_data [N_NEURONS];
  logic [OUT_BITS-1:0]           rb_sel;
  logic                          s2_free, s1_free, advance;

  for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
    logic we;
    assign we = cfg_we && (cfg_neuron == NW'(n));

    logicnets_lut_neuron #(
      .FAN_IN   (FAN_IN),
      .OUT_BITS (OUT_BITS)
    ) u_neuron (
      .clk_i      (clk),
      .rst_i      (rst),
      .we_i       (we),
      .cfg_addr_i (cfg_addr),
      .wdata_i    (cfg_wdata),
      .laddr_i    (s1_data_q[n*FAN_IN +: FAN_IN]),
      .ldata_o    (lut_out[n*OUT_BITS +: OUT_BITS]),
      .rdata_o    (rb_data[n])
    );
  end

  // Read-back select; an out-of-range neuron index matches nothing and yields 0.
  always_comb begin
    rb_sel = '0;
    for (int unsigned n = 0; n < N_NEURONS; n++) begin
      if (cfg_neuron == NW'(n)) rb_sel = rb_data[n];
    end
  end

  // Handshake and next-state for both pipeline stages and the read-back port.
  always_comb begin
    s2_free  = !out_valid_q || out_ready;
    s1_free  = !s1_valid_q || s2_free;
    advance  = s1_valid_q && s2_free;

    s1_valid_d = s1_free ? in_valid : s1_valid_q;
    s1_data_d  = (in_valid && s1_free) ? in_data : s1_data_q;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (advance) begin
      out_valid_d = 1'b1;
      out_data_d  = lut_out;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    cfg_rvalid_d = cfg_re;
    cfg_rdata_d  = cfg_re ? rb_sel : cfg_rdata_q;
  end

  // Pipeline and read-back registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      cfg_rdata_q  <= '0;
      cfg_rvalid_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      cfg_rdata_q  <= cfg_rdata_d;
      cfg_rvalid_q <= cfg_rvalid_d;
    end
  end

  assign in_ready   = s1_free;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign cfg_rdata  = cfg_rdata_q;
  assign cfg_rvalid = cfg_rvalid_q;

endmodule

// File: tb/tb_logicnets_lut_layer.sv
// Directed bench for logicnets_lut_layer with 6 neurons, 6-bit fan-in and
// 3-bit outputs, so an out-of-range neuron index (6) is expressible.
module tb_logicnets_lut_layer;

  localparam int unsigned NN = 6;
  localparam int unsigned FI = 6;
  localparam int unsigned OB = 3;

  logic                 clk;
  logic                 rst;
  logic [NN*FI-1:0]     in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [NN*OB-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 cfg_we;
  logic                 cfg_re;
  logic [2:0]           cfg_neuron;
  logic [FI-1:0]        cfg_addr;
  logic [OB-1:0]        cfg_wdata;
  logic [OB-1:0]        cfg_rdata;
  logic                 cfg_rvalid;

  int checks = 0;
  int errors = 0;

  logicnets_lut_layer #(
    .N_NEURONS (NN),
    .FAN_IN    (FI),
    .OUT_BITS  (OB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cfg_we     (cfg_we),
    .cfg_re     (cfg_re),
    .cfg_neuron (cfg_neuron),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .cfg_rvalid (cfg_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Input vector with neuron-0 and neuron-3 addresses set, all others 0.
  function automatic logic [NN*FI-1:0] mkv(input logic [FI-1:0] a0, input logic [FI-1:0] a3);
    logic [NN*FI-1:0] v;
    v = '0;
    v[0*FI +: FI] = a0;
    v[3*FI +: FI] = a3;
    return v;
  endfunction

  task automatic cfg_write(input logic [2:0] n, input logic [FI-1:0] a, input logic [OB-1:0] d);
    cfg_we = 1'b1; cfg_neuron = n; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input string tag, input logic [2:0] n, input logic [FI-1:0] a,
                          input logic [OB-1:0] exp);
    cfg_re = 1'b1; cfg_neuron = n; cfg_addr = a;
    tick();
    cfg_re = 1'b0;
    chk({tag, "_rvalid"}, 64'(cfg_rvalid), 64'd1);
    chk({tag, "_rdata"}, 64'(cfg_rdata), 64'(exp));
  endtask

  initial begin
    int acc;
    int idx;
    logic rdy;

    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_re = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_rvalid", 64'(cfg_rvalid), 64'd0);
    chk("rst_rdata", 64'(cfg_rdata), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Program tables: neuron 0 addr k = k (k=1..4), neuron 3 addr 5 = 1.
    for (int k = 1; k <= 4; k++) cfg_write(3'd0, FI'(k), OB'(k));
    cfg_write(3'd3, 6'd5, 3'd1);

    // Streaming: four back-to-back vectors, 2-cycle latency.
    in_valid = 1'b1; in_data = mkv(6'd1, 6'd0);
    tick();
    chk("st_lat1_valid", 64'(out_valid), 64'd0);
    in_data = mkv(6'd2, 6'd0);
    tick();
    chk("st_v1", 64'(out_data), 64'd1);
    chk("st_v1_valid", 64'(out_valid), 64'd1);
    in_data = mkv(6'd3, 6'd0);
    tick();
    chk("st_v2", 64'(out_data), 64'd2);
    in_data = mkv(6'd4, 6'd0);
    tick();
    chk("st_v3", 64'(out_data), 64'd3);
    in_valid = 1'b0;
    tick();
    chk("st_v4", 64'(out_data), 64'd4);
    chk("st_v4_valid", 64'(out_valid), 64'd1);
    tick();
    chk("st_drain_valid", 64'(out_valid), 64'd0);

    // Neuron 3 lookup: only its slice becomes 1.
    in_valid = 1'b1; in_data = mkv(6'd0, 6'd5);
    tick();
    in_valid = 1'b0;
    chk("n3_lat_valid", 64'(out_valid), 64'd0);
    tick();
    chk("n3_valid", 64'(out_valid), 64'd1);
    chk("n3_data", 64'(out_data), 64'h200);
    tick();

    // Backpressure: out_ready low for 5 cycles with input always offered.
    out_ready = 1'b0; acc = 0; idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data = mkv(FI'(idx + 1), 6'd0);
      rdy = in_ready;
      tick();
      if (rdy) begin
        acc++;
        idx++;
      end
      if (c >= 1) begin
        chk("bp_hold_data", 64'(out_data), 64'd1);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
      end
    end
    chk("bp_accepted", 64'(acc), 64'd2);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", 64'(in_ready), 64'd1);
    tick();
    chk("bp_out2", 64'(out_data), 64'd2);
    in_valid = 1'b0;
    tick();
    chk("bp_out3", 64'(out_data), 64'd3);
    chk("bp_out3_valid", 64'(out_valid), 64'd1);
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Write in the same cycle S2 looks up the same entry: old value wins.
    in_valid = 1'b1; in_data = mkv(6'd0, 6'd0);
    tick();
    cfg_we = 1'b1; cfg_neuron = 3'd0; cfg_addr = 6'd0; cfg_wdata = 3'd1;
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("wl_old", 64'(out_data), 64'd0);
    chk("wl_old_valid", 64'(out_valid), 64'd1);
    tick();
    chk("wl_new", 64'(out_data), 64'd1);

    // Read-back of a 3-bit entry, with a one-cycle rvalid pulse.
    cfg_write(3'd5, 6'd63, 3'b101);
    chk("rb_idle_rvalid", 64'(cfg_rvalid), 64'd0);
    cfg_read("rb_n5", 3'd5, 6'd63, 3'b101);
    tick();
    chk("rb_pulse_end", 64'(cfg_rvalid), 64'd0);

    // Write and read of the same entry together return the old value.
    cfg_we = 1'b1; cfg_wdata = 3'b010;
    cfg_read("rb_wr_same", 3'd5, 6'd63, 3'b101);
    cfg_we = 1'b0;
    cfg_read("rb_after_wr", 3'd5, 6'd63, 3'b010);

    // Out-of-range neuron: write ignored, read returns 0 with rvalid.
    cfg_write(3'd6, 6'd63, 3'b111);
    cfg_read("rb_oor", 3'd6, 6'd63, 3'b000);
    cfg_read("rb_oor_nowr", 3'd5, 6'd63, 3'b010);

    // Reset with two vectors in flight.
    in_valid = 1'b1; in_data = mkv(6'd1, 6'd0);
    tick();
    in_data = mkv(6'd2, 6'd0);
    tick();
    in_valid = 1'b0;
    chk("mr_pre_valid", 64'(out_valid), 64'd1);
    chk("mr_pre_data", 64'(out_data), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_async_valid", 64'(out_valid), 64'd0);
    chk("mr_async_data", 64'(out_data), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("mr_discard_valid", 64'(out_valid), 64'd0);
    cfg_read("mr_tbl_n0", 3'd0, 6'd1, 3'b000);
    cfg_read("mr_tbl_n5", 3'd5, 6'd63, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/logicnets_lut_layer.md
# logicnets_lut_layer

Parametrised, pipelined LogicNets layer: N_NEURONS independent FAN_IN-input lookup neurons, each with a truth table of OUT_BITS-wide entries. Tables are held in registers and written or read back at run time through a configuration port, not fixed at synthesis. The block sits between the input-wiring stage and the next layer. It carries a valid/ready stream with full backpressure and produces one output vector per accepted input vector.

## Interface
- N_NEURONS, 8: neurons in the layer.
- FAN_IN, 6: input bits per neuron; each table has 2^FAN_IN entries.
- OUT_BITS, 1: output bits per neuron (>1 gives quantised multi-bit activations).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N_NEURONS*FAN_IN  neuron n's address is bits [n*FAN_IN +: FAN_IN], pre-routed upstream.
- in_valid  in  1  input vector valid.
- in_ready  out  1  layer accepts in_data this cycle.
- out_data  out  N_NEURONS*OUT_BITS  neuron n's result is bits [n*OUT_BITS +: OUT_BITS].
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts out_data.
- cfg_we  in  1  table write strobe.
- cfg_re  in  1  table read-back strobe.
- cfg_neuron  in  $clog2(N_NEURONS)  target neuron.
- cfg_addr  in  FAN_IN  table entry index.
- cfg_wdata  in  OUT_BITS  entry value to write.
- cfg_rdata  out  OUT_BITS  read-back data.
- cfg_rvalid  out  1  cfg_rdata valid; one-cycle pulse.

## Operation
- Reset values:
  - all table entries 0;
  - s1_valid, out_valid, cfg_rvalid are 0;
  - stage-1 data register, out_data and cfg_rdata are 0.
- Stage 1 (S1): registers in_data.
- Stage 2 (S2): looks up every neuron's table at its S1 address and registers the result into out_data.
- Pipeline flow:
  - s2_free = !out_valid || out_ready.
  - s1_free = !s1_valid || s2_free.
  - in_ready = s1_free.
  - Input is accepted on in_valid && in_ready.
  - S1 advances to S2 when s1_valid && s2_free.
  - out_valid clears when out_ready is high and no S1 item advances in the same cycle.
- Bubbles collapse: an empty stage always accepts, independent of out_ready.
- While out_valid && !out_ready, out_data and out_valid hold stable. Upstream is stalled only once S1 is also full.
- Table write:
  - On cfg_we, entry [cfg_neuron][cfg_addr] takes cfg_wdata at the clock edge.
  - Writes are legal at any time, including while stalled.
  - A lookup in the same cycle as a write reads the old value; lookups in later cycles read the new value.
- Read-back:
  - On cfg_re, cfg_rdata takes entry [cfg_neuron][cfg_addr] and cfg_rvalid pulses the next cycle.
  - If cfg_we and cfg_re target the same entry in the same cycle, the old value is returned.
- cfg_neuron >= N_NEURONS: the write is ignored; the read returns 0 with cfg_rvalid still pulsed.
- The cfg port is independent of the stream handshake; cfg activity never stalls the pipeline.

## Timing
- Latency is 2 cycles from an accepted input to out_valid, with no stall.
- Throughput is 1 vector per cycle while out_ready is held high.
- Read-back latency is 1 cycle.
- Reset asserted mid-operation:
  - in-flight vectors are discarded;
  - tables clear to 0;
  - outputs return to their reset values immediately (asynchronous).
- Deassertion is synchronised by the integrating top level; this block assumes a clean release.
- in_ready depends combinationally on out_ready (through s2_free); this is the only combinational input-to-output path.

## Structure
- Package logicnets_pkg holds:
  - table-depth function tbl_depth(FAN_IN) = 2**FAN_IN;
  - a localparam for the default FAN_IN;
  - typedef neuron_idx_t for the neuron index.
- Sub-module logicnets_lut_neuron, one instance per neuron, contains:
  - the 2^FAN_IN x OUT_BITS register table;
  - a write port gated by cfg_we && cfg_neuron==n;
  - the lookup read mux;
  - the read-back mux.
- The top level holds S1, the output register, the handshake logic, and the read-back selection across neurons.

## Test plan
- Reset then stream:
  - all out_data are 0;
  - inputs presented on cycles 1..4 appear on out_valid on cycles 3..6 with out_ready high.
- Write neuron 3, addr 6'b000101 = 1, then present a vector whose neuron-3 slice is 6'b000101 and all other slices 0:
  - out_data bit 3 = 1, all other bits 0, 2 cycles after acceptance.
- Backpressure:
  - hold out_ready low for 5 cycles with in_valid high;
  - exactly 2 vectors are accepted, then in_ready drops;
  - out_data stays stable;
  - on release, vectors emerge in order with no loss or duplication.
- Simultaneous write and lookup:
  - neuron 0, addr 0: write 1 in the same cycle S2 looks up addr 0; the result is the old value 0;
  - the next vector with addr 0 returns 1.
- Read-back with OUT_BITS=3:
  - write neuron 5, addr 63 = 3'b101, then cfg_re the same entry;
  - cfg_rdata = 3'b101 with a one-cycle cfg_rvalid pulse;
  - a read of cfg_neuron = N_NEURONS returns 0.
- Reset mid-stream with 2 vectors in flight:
  - out_valid goes low immediately;
  - a read-back of the previously written entry returns 0.
